zl_rs_encoder: RTL and testbench

//  DVB-S outer coder: systematic RS(204,188,t=8), shortened from RS(255,239).

---
 rtl/zl_rs_encoder_pkg.sv | 36 +++
 rtl/zl_gf_const_mul.sv | 25 ++
 rtl/zl_rs_encoder.sv | 142 ++++++++++++++
 tb/tb_zl_rs_encoder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zl_rs_encoder_pkg.sv
// Shared DVB-S outer-coder constants, state encoding and GF(2^8) helpers.
// Replaces the legacy zl_dvb_defs.v include for this block.
package zl_rs_encoder_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = 8;
  localparam int unsigned DATA_LEN   = 188;
  localparam int unsigned PARITY_LEN = 16;

  localparam logic [BYTE_W-1:0] SYNC_BYTE     = 8'h47;
  localparam logic [BYTE_W-1:0] SYNC_BYTE_INV = 8'hB8;
  // Low byte of the field polynomial x^8+x^4+x^3+x^2+1
  localparam logic [BYTE_W-1:0] GF_POLY       = 8'h1D;

  // Generator coefficients g15..g0 (g16 = 1 is implicit)
  localparam logic [PARITY_LEN-1:0][BYTE_W-1:0] G_COEF = {
    8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
    8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59
  };

  typedef enum logic [1:0] {
    S_MSG    = 2'd0,
    S_PARITY = 2'd1,
    S_HUNT   = 2'd2
  } state_e;

  // Multiply by a (0x02) modulo the field polynomial
  function automatic logic [BYTE_W-1:0] gf_xtime(input logic [BYTE_W-1:0] a);
    return {a[BYTE_W-2:0], 1'b0} ^ (a[BYTE_W-1] ? GF_POLY : BYTE_W'(0));
  endfunction

  function automatic logic is_sync(input logic [BYTE_W-1:0] b);
    return (b == SYNC_BYTE) || (b == SYNC_BYTE_INV);
  endfunction

endpackage

// File: rtl/zl_gf_const_mul.sv
// Constant GF(2^8) multiplier: xor of the shifted-and-reduced input copies
// selected by the set bits of COEF.
module zl_gf_const_mul
  import zl_rs_encoder_pkg::*;
#(
  parameter logic [BYTE_W-1:0] COEF = 8'h01
) (
  input  logic [BYTE_W-1:0] data_in,
  output logic [BYTE_W-1:0] data_out
);

  logic [BYTE_W-1:0] term;

  always_comb begin
    data_out = '0;
    term     = data_in;
    for (int k = 0; k < int'(BYTE_W); k++) begin
      if (COEF[k]) begin
        data_out = data_out ^ term;
      end
      term = gf_xtime(term);
    end
  end

endmodule

// File: rtl/zl_rs_encoder.sv
// Systematic RS(204,188,t=8) encoder: 188 message bytes pass through, then 16 parity bytes.
// Optional sync hunting on byte 0 is enabled by ZL_RS_ENCODER_SYNC_CHECK_EN.
module zl_rs_encoder
  import zl_rs_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              data_in_req,
  output logic              data_in_ack,
  input  logic [BYTE_W-1:0] data_in,
  output logic              data_out_req,
  input  logic              data_out_ack,
  output logic [BYTE_W-1:0] data_out
);

`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
  localparam state_e RESET_STATE = S_HUNT;
`else
  localparam state_e RESET_STATE = S_MSG;
`endif

  localparam logic [CNT_W-1:0] MSG_LAST    = CNT_W'(DATA_LEN - 1);
  localparam logic [CNT_W-1:0] PARITY_LAST = CNT_W'(PARITY_LEN - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [BYTE_W-1:0] p_q [PARITY_LEN];
  logic [BYTE_W-1:0] p_d [PARITY_LEN];

  logic [BYTE_W-1:0] fb_c;
  logic [BYTE_W-1:0] gprod_c [PARITY_LEN];
  logic              drop_c;
  logic              msg_xfer_c;

  assign fb_c = data_in ^ p_q[PARITY_LEN-1];

  // Feedback byte times each generator coefficient
  for (genvar gi = 0; gi < int'(PARITY_LEN); gi++) begin : g_mul
    zl_gf_const_mul #(
      .COEF (G_COEF[gi])
    ) u_mul (
      .data_in  (fb_c),
      .data_out (gprod_c[gi])
    );
  end

  // A non-sync byte 0 is dropped instead of starting a packet
`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
  logic sync_c;
  assign sync_c = is_sync(data_in);
  assign drop_c = (count_q == '0) && !sync_c;
`else
  assign drop_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    p_d          = p_q;
    data_in_ack  = 1'b0;
    data_out_req = 1'b0;
    data_out     = data_in;
    msg_xfer_c   = 1'b0;

    case (state_q)
      S_MSG: begin
        if (drop_c) begin
          data_in_ack = data_in_req;
          if (data_in_req) begin
            state_d = S_HUNT;
          end
        end else begin
          data_out_req = data_in_req;
          data_in_ack  = data_in_req && data_out_ack;
          msg_xfer_c   = data_in_req && data_out_ack;
        end
      end

      S_PARITY: begin
        data_out_req = 1'b1;
        data_out     = p_q[PARITY_LEN-1];
        if (data_out_ack) begin
          for (int i = int'(PARITY_LEN) - 1; i > 0; i--) begin
            p_d[i] = p_q[i-1];
          end
          p_d[0] = '0;
          if (count_q == PARITY_LAST) begin
            count_d = '0;
            state_d = S_MSG;
            for (int i = 0; i < int'(PARITY_LEN); i++) begin
              p_d[i] = '0;
            end
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
      S_HUNT: begin
        data_out_req = data_in_req && sync_c;
        data_in_ack  = data_in_req && (!sync_c || data_out_ack);
        msg_xfer_c   = data_in_req && sync_c && data_out_ack;
      end
`endif

      default: begin
        state_d = S_MSG;
      end
    endcase

    // LFSR division step for an accepted message byte
    if (msg_xfer_c) begin
      p_d[0] = gprod_c[0];
      for (int i = 1; i < int'(PARITY_LEN); i++) begin
        p_d[i] = p_q[i-1] ^ gprod_c[i];
      end
      if (count_q == MSG_LAST) begin
        count_d = '0;
        state_d = S_PARITY;
      end else begin
        count_d = count_q + CNT_W'(1);
        state_d = S_MSG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      count_q <= '0;
      for (int i = 0; i < int'(PARITY_LEN); i++) begin
        p_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_zl_rs_encoder.sv
// Bench for zl_rs_encoder: RS(204,188) reference by polynomial long division,
// syndrome checks, backpressure, mid-packet reset and optional sync hunting.
module tb_zl_rs_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       data_in_req;
  logic       data_in_ack;
  logic [7:0] data_in;
  logic       data_out_req;
  logic       data_out_ack;
  logic [7:0] data_out;

  int tests = 0;
  int fails = 0;

  logic [7:0] pkt   [188];
  logic [7:0] exp_b [204];
  logic [7:0] got   [204];
  logic [7:0] gen   [17];
  logic [7:0] spec_par [16] = '{8'd59, 8'd13, 8'd104, 8'd189, 8'd68, 8'd209, 8'd30, 8'd8,
                                8'd163, 8'd65, 8'd41, 8'd229, 8'd98, 8'd50, 8'd36, 8'd59};

  always #5 clk = ~clk;

  zl_rs_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in_req  (data_in_req),
    .data_in_ack  (data_in_ack),
    .data_in      (data_in),
    .data_out_req (data_out_req),
    .data_out_ack (data_out_ack),
    .data_out     (data_out)
  );

  // Carry-less product reduced modulo 0x11D
  function automatic logic [7:0] gf_mul_ref(input logic [7:0] a, input logic [7:0] b);
    int prod = 0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int k = 14; k >= 8; k--) if (prod[k]) prod = prod ^ (32'h11D << (k - 8));
    return prod[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // g(x) = prod (x + a^i), i = 0..15; gen[d] is the x^d coefficient
  task automatic build_gen();
    logic [7:0] root = 8'h01;
    for (int d = 0; d < 17; d++) gen[d] = (d == 0) ? 8'h01 : 8'h00;
    for (int i = 0; i < 16; i++) begin
      for (int d = 16; d > 0; d--) gen[d] = gen[d-1] ^ gf_mul_ref(root, gen[d]);
      gen[0] = gf_mul_ref(root, gen[0]);
      root = gf_mul_ref(root, 8'h02);
    end
  endtask

  // Codeword = message followed by (m(x) * x^16) mod g(x), highest degree first
  task automatic build_expected();
    logic [7:0] poly [204];
    logic [7:0] c;
    for (int k = 0; k < 204; k++) poly[k] = (k < 188) ? pkt[k] : 8'h00;
    for (int k = 0; k < 188; k++) begin
      c = poly[k];
      for (int j = 0; j <= 16; j++) poly[k+j] = poly[k+j] ^ gf_mul_ref(c, gen[16-j]);
    end
    for (int k = 0; k < 204; k++) exp_b[k] = (k < 188) ? pkt[k] : poly[k];
  endtask

  task automatic check_syndrome();
    logic [7:0] root = 8'h01;
    logic [7:0] s;
    for (int i = 0; i < 16; i++) begin
      s = 8'h00;
      for (int k = 0; k < 204; k++) s = gf_mul_ref(s, root) ^ got[k];
      check("syndrome", 32'(s), 32'd0);
      root = gf_mul_ref(root, 8'h02);
    end
  endtask

  task automatic random_packet();
    pkt[0] = ($urandom_range(1) == 0) ? 8'h47 : 8'hB8;
    for (int k = 1; k < 188; k++) pkt[k] = 8'($urandom);
  endtask

  // Streams pkt through the DUT with random stalls, checking every cycle
  task automatic run_packet(input int stall_pct, input int hold_at, output int cycles);
    int in_idx = 0;
    int out_idx = 0;
    int hold = 0;
    logic req, ack;
    build_expected();
    cycles = 0;
    while (out_idx < 204 && cycles < 4000) begin
      @(negedge clk);
      req = ($urandom_range(99) >= stall_pct);
      ack = ($urandom_range(99) >= stall_pct);
      if (hold_at >= 0 && out_idx == 188 + hold_at && hold < 5) begin
        ack = 1'b0;
        hold++;
      end
      data_in_req  = req;
      data_in      = (in_idx < 188 && req) ? pkt[in_idx] : 8'($urandom);
      data_out_ack = ack;
      #1;
      if (out_idx < 188) begin
        check("msg_out_req", 32'(data_out_req), 32'(req));
        check("msg_in_ack", 32'(data_in_ack), 32'(req && ack));
        if (req) check("msg_data", 32'(data_out), 32'(exp_b[out_idx]));
      end else begin
        check("par_out_req", 32'(data_out_req), 32'd1);
        check("par_in_ack", 32'(data_in_ack), 32'd0);
        check("par_data", 32'(data_out), 32'(exp_b[out_idx]));
      end
      if ((out_idx < 188) ? (req && ack) : ack) begin
        got[out_idx] = data_out;
        if (out_idx < 188) in_idx++;
        out_idx++;
      end
      cycles++;
    end
    check("packet_done", 32'(out_idx), 32'd204);
  endtask

  initial begin
    int cyc;
    rst_n        = 1'b0;
    data_in_req  = 1'b0;
    data_in      = 8'h00;
    data_out_ack = 1'b0;
    build_gen();

    // Reset values: pass-through request, no consumption without downstream ack
    @(negedge clk);
    data_in_req = 1'b1;
    data_in     = 8'h47;
    #1;
    check("rst_out_req", 32'(data_out_req), 32'd1);
    check("rst_in_ack", 32'(data_in_ack), 32'd0);
    check("rst_data", 32'(data_out), 32'h47);
    @(negedge clk);
    data_in_req = 1'b0;
    rst_n       = 1'b1;

    // All-zero packets back to back, no stalls
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < 188; k++) pkt[k] = 8'h00;
`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
      pkt[0] = 8'h47;
`endif
      run_packet(0, -1, cyc);
      check("zero_cycles", 32'(cyc), 32'd204);
`ifndef ZL_RS_ENCODER_SYNC_CHECK_EN
      for (int k = 188; k < 204; k++) check("zero_parity", 32'(got[k]), 32'd0);
`endif
      check_syndrome();
    end

    // Single 0x01 in the last message byte exposes g(x) directly
    for (int k = 0; k < 188; k++) pkt[k] = 8'h00;
    pkt[187] = 8'h01;
`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
    pkt[0] = 8'hB8;
`endif
    run_packet(0, -1, cyc);
`ifndef ZL_RS_ENCODER_SYNC_CHECK_EN
    for (int k = 0; k < 16; k++) check("unit_parity", 32'(got[188+k]), 32'(spec_par[k]));
`endif
    check_syndrome();

    // Random packets with random stalls on both sides
    for (int n = 0; n < 6; n++) begin
      random_packet();
      run_packet(30, -1, cyc);
      check_syndrome();
    end

    // Downstream stall at parity byte 7
    random_packet();
    run_packet(0, 7, cyc);
    check("hold_cycles", 32'(cyc), 32'd209);
    check_syndrome();

    // Reset at message byte 100 discards the partial packet
    random_packet();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      data_in_req  = 1'b1;
      data_out_ack = 1'b1;
      data_in      = pkt[k];
    end
    @(negedge clk);
    rst_n        = 1'b0;
    data_in_req  = 1'b1;
    data_out_ack = 1'b0;
    data_in      = 8'hB8;
    #1;
    check("midrst_out_req", 32'(data_out_req), 32'd1);
    check("midrst_in_ack", 32'(data_in_ack), 32'd0);
    check("midrst_data", 32'(data_out), 32'hB8);
    @(negedge clk);
    rst_n = 1'b1;
    random_packet();
    run_packet(20, -1, cyc);
    check_syndrome();

`ifdef ZL_RS_ENCODER_SYNC_CHECK_EN
    // Sync hunting: junk bytes dropped, then a bad byte 0 forces a re-hunt
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      data_in_req  = 1'b1;
      data_out_ack = 1'b1;
      data_in      = (k == 0) ? 8'h12 : 8'h34;
      #1;
      check("hunt_out_req", 32'(data_out_req), 32'd0);
      check("hunt_in_ack", 32'(data_in_ack), 32'd1);
    end
    random_packet();
    pkt[0] = 8'h47;
    run_packet(0, -1, cyc);
    check("sync_cycles", 32'(cyc), 32'd204);
    check_syndrome();
    @(negedge clk);
    data_in_req  = 1'b1;
    data_out_ack = 1'b1;
    data_in      = 8'h55;
    #1;
    check("bad0_out_req", 32'(data_out_req), 32'd0);
    check("bad0_in_ack", 32'(data_in_ack), 32'd1);
    @(negedge clk);
    data_in = 8'h66;
    #1;
    check("rehunt_out_req", 32'(data_out_req), 32'd0);
    @(negedge clk);
    data_in      = 8'hB8;
    data_out_ack = 1'b0;
    #1;
    check("rehunt_sync_req", 32'(data_out_req), 32'd1);
    check("rehunt_sync_ack", 32'(data_in_ack), 32'd0);
    random_packet();
    run_packet(25, -1, cyc);
    check_syndrome();
`endif

    @(negedge clk);
    data_in_req  = 1'b0;
    data_out_ack = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
